vend_coin_ctrl: RTL and testbench

Controller that sits in front of the candy vending machine datapath and shares one credit accumulator and one candy dispenser between two coin slots (A and B). It arbitrates coin acceptance round-robin, accumulates credit, and requests a dispense once credit reaches the price. It then returns change in 5-unit pulses, or refunds the full credit on cancel or timeout.

---
 rtl/vend_coin_ctrl.sv | 116 +++++++++++
 tb/tb_vend_coin_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vend_coin_ctrl.sv
// Two-slot coin acceptor with round-robin arbitration, shared credit, dispense
// handshake and 5-unit change/refund pulses.
module vend_coin_ctrl #(
    parameter int unsigned PRICE   = 15,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] coin_a,
    input  logic       coin_a_vld,
    output logic       coin_a_rdy,
    input  logic [3:0] coin_b,
    input  logic       coin_b_vld,
    output logic       coin_b_rdy,
    input  logic       cancel,
    output logic       disp_req,
    input  logic       disp_ack,
    output logic       change_pulse,
    output logic [5:0] credit,
    output logic       err_coin
);

    localparam logic [5:0] PRICE6  = 6'(PRICE);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {COLLECT, DISPENSE, RETURN} state_t;

    state_t      state;
    logic        last_b;
    logic [7:0]  tcnt;
    logic        grant_a;
    logic        accept;
    logic [3:0]  sel_code;
    logic [5:0]  val;
    logic        valid_acc;
    logic        bad_acc;
    logic [5:0]  credit_next;

    always_comb begin
        // last_b resets high so that A wins the first contended cycle
        grant_a     = coin_a_vld & (~coin_b_vld | last_b);
        coin_a_rdy  = grant_a & (state == COLLECT);
        coin_b_rdy  = coin_b_vld & ~grant_a & (state == COLLECT);
        accept      = coin_a_rdy | coin_b_rdy;
        sel_code    = coin_a_rdy ? coin_a : coin_b;
        val         = '0;
        if (accept) begin
            case (sel_code)
                4'b0101: val = 6'd5;
                4'b1010: val = 6'd10;
                default: val = '0;
            endcase
        end
        valid_acc   = accept & (val != '0);
        bad_acc     = accept & (val == '0);
        credit_next = credit + val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= COLLECT;
            last_b       <= 1'b1;
            tcnt         <= '0;
            credit       <= '0;
            disp_req     <= 1'b0;
            change_pulse <= 1'b0;
            err_coin     <= 1'b0;
        end else begin
            err_coin     <= bad_acc;
            change_pulse <= 1'b0;
            if (accept)
                last_b <= coin_b_rdy;
            case (state)
                COLLECT: begin
                    if (valid_acc) begin
                        credit <= credit_next;
                        tcnt   <= '0;
                        if (credit_next >= PRICE6) begin
                            state    <= DISPENSE;
                            disp_req <= 1'b1;
                        end else if (cancel) begin
                            state <= RETURN;
                        end
                    end else if (credit == '0) begin
                        tcnt <= '0;
                    end else if (cancel || tcnt == TO_LAST) begin
                        state <= RETURN;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                DISPENSE: begin
                    tcnt <= '0;
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        credit   <= credit - PRICE6;
                        state    <= (credit != PRICE6) ? RETURN : COLLECT;
                    end
                end
                RETURN: begin
                    tcnt <= '0;
                    if (credit <= 6'd5) begin
                        state <= COLLECT;
                    end
                    if (credit != '0) begin
                        change_pulse <= 1'b1;
                        credit       <= credit - 6'd5;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_coin_ctrl.sv
// Directed table-driven bench for vend_coin_ctrl (PRICE 15, TIMEOUT 255).
module tb_vend_coin_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] coin_a, coin_b;
    logic       coin_a_vld, coin_b_vld, coin_a_rdy, coin_b_rdy;
    logic       cancel, disp_req, disp_ack, change_pulse, err_coin;
    logic [5:0] credit;

    int unsigned napplied = 0;
    int unsigned miscompares = 0;

    vend_coin_ctrl #(.PRICE(15), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .coin_a(coin_a), .coin_a_vld(coin_a_vld), .coin_a_rdy(coin_a_rdy),
        .coin_b(coin_b), .coin_b_vld(coin_b_vld), .coin_b_rdy(coin_b_rdy),
        .cancel(cancel), .disp_req(disp_req), .disp_ack(disp_ack),
        .change_pulse(change_pulse), .credit(credit), .err_coin(err_coin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic       av;
        logic [3:0] b;
        logic       bv;
        logic       cn;
        logic       ack;
        logic [1:0] rdy;
        logic       dq;
        logic       ch;
        logic [5:0] cr;
        logic       er;
    } vec_t;

    vec_t vq[$];

    localparam logic [3:0] I = 4'h0, C5 = 4'b0101, C10 = 4'b1010, BAD = 4'b0011;

    function automatic vec_t mk(logic [3:0] a, logic av, logic [3:0] b, logic bv,
                                logic cn, logic ack, logic [1:0] rdy, logic dq,
                                logic ch, logic [5:0] cr, logic er);
        vec_t v;
        v.a = a; v.av = av; v.b = b; v.bv = bv; v.cn = cn; v.ack = ack;
        v.rdy = rdy; v.dq = dq; v.ch = ch; v.cr = cr; v.er = er;
        return v;
    endfunction

    task automatic drive(logic [3:0] a, logic av, logic [3:0] b, logic bv,
                         logic cn, logic ack);
        coin_a = a; coin_a_vld = av; coin_b = b; coin_b_vld = bv;
        cancel = cn; disp_ack = ack;
    endtask

    task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
        napplied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rdy_s;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // rdy (sampled before the edge), disp_req, change_pulse, credit, err_coin after the edge
        vq.push_back(mk(I,  0, I,  0, 0, 0, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(C5, 1, C5, 1, 0, 0, 2'b10, 0, 0, 6'd5,  0));
        vq.push_back(mk(C5, 1, C5, 1, 0, 0, 2'b01, 0, 0, 6'd10, 0));
        vq.push_back(mk(C5, 1, C5, 1, 0, 0, 2'b10, 1, 0, 6'd15, 0));
        vq.push_back(mk(C5, 1, C5, 1, 0, 0, 2'b00, 1, 0, 6'd15, 0));
        vq.push_back(mk(I,  0, I,  0, 0, 1, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(C5, 1, I,  0, 0, 0, 2'b10, 0, 0, 6'd5,  0));
        vq.push_back(mk(C10,1, I,  0, 0, 0, 2'b10, 1, 0, 6'd15, 0));
        vq.push_back(mk(C5, 1, I,  0, 0, 0, 2'b00, 1, 0, 6'd15, 0));
        vq.push_back(mk(I,  0, I,  0, 0, 1, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(I,  0, I,  0, 0, 0, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(C10,1, I,  0, 0, 0, 2'b10, 0, 0, 6'd10, 0));
        vq.push_back(mk(C10,1, I,  0, 0, 0, 2'b10, 1, 0, 6'd20, 0));
        vq.push_back(mk(I,  0, I,  0, 0, 1, 2'b00, 0, 0, 6'd5,  0));
        vq.push_back(mk(I,  0, I,  0, 0, 0, 2'b00, 0, 1, 6'd0,  0));
        vq.push_back(mk(I,  0, I,  0, 0, 0, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(BAD,1, I,  0, 0, 0, 2'b10, 0, 0, 6'd0,  1));
        vq.push_back(mk(I,  0, I,  0, 0, 0, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(C5, 1, I,  0, 0, 0, 2'b10, 0, 0, 6'd5,  0));
        vq.push_back(mk(C10,1, I,  0, 1, 0, 2'b10, 1, 0, 6'd15, 0));
        vq.push_back(mk(I,  0, I,  0, 0, 1, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(C10,1, I,  0, 0, 0, 2'b10, 0, 0, 6'd10, 0));
        vq.push_back(mk(I,  0, I,  0, 1, 0, 2'b00, 0, 0, 6'd10, 0));
        vq.push_back(mk(I,  0, I,  0, 1, 0, 2'b00, 0, 1, 6'd5,  0));
        vq.push_back(mk(I,  0, I,  0, 0, 0, 2'b00, 0, 1, 6'd0,  0));
        vq.push_back(mk(I,  0, I,  0, 0, 0, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(I,  0, I,  0, 1, 0, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(I,  0, I,  0, 0, 1, 2'b00, 0, 0, 6'd0,  0));
        vq.push_back(mk(I,  0, C5, 1, 0, 0, 2'b01, 0, 0, 6'd5,  0));
        vq.push_back(mk(C5, 1, I,  0, 1, 0, 2'b10, 0, 0, 6'd10, 0));
        vq.push_back(mk(C5, 1, I,  0, 0, 0, 2'b00, 0, 1, 6'd5,  0));
        vq.push_back(mk(I,  0, I,  0, 0, 0, 2'b00, 0, 1, 6'd0,  0));
        vq.push_back(mk(I,  0, I,  0, 0, 0, 2'b00, 0, 0, 6'd0,  0));

        rst = 1'b0;
        drive(I, 0, I, 0, 0, 0);
        #3;
        cmp("reset_state", {5'd0, coin_a_rdy, coin_b_rdy, disp_req, change_pulse, credit, err_coin}, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].a, vq[i].av, vq[i].b, vq[i].bv, vq[i].cn, vq[i].ack);
            #1;
            rdy_s = {coin_a_rdy, coin_b_rdy};
            step();
            cmp($sformatf("vec%0d", i),
                {5'd0, rdy_s, disp_req, change_pulse, credit, err_coin},
                {5'd0, vq[i].rdy, vq[i].dq, vq[i].ch, vq[i].cr, vq[i].er});
        end

        // Timeout: an invalid coin mid-wait must not restart the counter
        @(negedge clk);
        drive(C5, 1, I, 0, 0, 0);
        step();
        cmp("to_accept", {10'd0, credit}, {10'd0, 6'd5});
        for (int i = 1; i <= 254; i++) begin
            @(negedge clk);
            if (i == 100) drive(BAD, 1, I, 0, 0, 0);
            else          drive(I, 0, I, 0, 0, 0);
            step();
            if (i == 100) cmp("to_bad_coin", {15'd0, err_coin}, 16'd1);
        end
        cmp("to_hold_254", {9'd0, change_pulse, credit}, {9'd0, 1'b0, 6'd5});
        step();
        cmp("to_enter_255", {9'd0, change_pulse, credit}, {9'd0, 1'b0, 6'd5});
        @(negedge clk);
        drive(C5, 1, I, 0, 0, 0);
        #1;
        cmp("to_rdy_in_return", {15'd0, coin_a_rdy}, 16'd0);
        step();
        cmp("to_pulse", {9'd0, change_pulse, credit}, {9'd0, 1'b1, 6'd0});
        @(negedge clk);
        drive(I, 0, I, 0, 0, 0);
        step();
        cmp("to_done", {9'd0, change_pulse, credit}, {9'd0, 1'b0, 6'd0});

        // Reset while dispensing with change owed
        @(negedge clk);
        drive(C10, 1, I, 0, 0, 0);
        step();
        @(negedge clk);
        step();
        cmp("rst_pre", {9'd0, disp_req, credit}, {9'd0, 1'b1, 6'd20});
        #2;
        rst = 1'b0;
        #1;
        cmp("rst_async", {8'd0, disp_req, change_pulse, credit}, 16'd0);
        drive(I, 0, I, 0, 0, 1);
        step();
        @(negedge clk);
        rst = 1'b1;
        drive(I, 0, I, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            cmp($sformatf("rst_after%0d", i), {8'd0, disp_req, change_pulse, credit}, 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", napplied, miscompares);
        $finish;
    end

endmodule
